// File: rtl/cpu_types_pkg.sv
//============================================================================
// Module : cpu_types_pkg
// Brief  : Shared CPU types: word bus type, I-cache frame/address structs.
// Rev    : 1.0 - initial release with I-cache types
//============================================================================
`default_nettype none
`timescale 1ns/1ps

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef enum logic [0:0] {
        ICACHE_IDLE = 1'b0,
        ICACHE_FILL = 1'b1
    } icache_state_t;

endpackage

`default_nettype wire

// File: rtl/icache_direct_if.sv
//============================================================================
// Module : icache_direct_if
// Brief  : Fetch-side and refill-side signals of the instruction cache.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

interface icache_direct_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  halt;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    // master drives the datapath and memory-controller side; slave is the cache
    modport master (
        output imemREN, imemaddr, halt, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

    modport slave (
        input  imemREN, imemaddr, halt, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

endinterface

`default_nettype wire

// File: rtl/icache_direct_ctrl.sv
//============================================================================
// Module : icache_ctrl
// Brief  : IDLE/FILL refill controller, miss address latch, hit/miss counters.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module icache_ctrl
    import cpu_types_pkg::*;
#(
    parameter int IDX_W = ICACHE_IDX_W,
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             imemREN,
    input  word_t            imemaddr,
    input  logic             match,
    input  logic             ihit,
    input  logic             halt,
    input  logic             iwait,
    output logic             idle,
    output logic             iREN,
    output word_t            iaddr,
    output logic             fill_we,
    output logic [IDX_W-1:0] fill_idx,
    output logic [TAG_W-1:0] fill_tag,
    output word_t            hit_count,
    output word_t            miss_count
);

    icache_state_t state_q, state_d;
    word_t         miss_addr_q, miss_addr_d;
    word_t         hit_count_q, hit_count_d;
    word_t         miss_count_q, miss_count_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ICACHE_IDLE;
            miss_addr_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        miss_count_d = miss_count_q;
        hit_count_d  = hit_count_q + {31'd0, ihit};
        iREN         = 1'b0;
        fill_we      = 1'b0;
        case (state_q)
            ICACHE_IDLE: begin
                if (imemREN && !match && !halt) begin
                    miss_addr_d  = imemaddr & 32'hFFFF_FFFC;
                    miss_count_d = miss_count_q + 32'd1;
                    state_d      = ICACHE_FILL;
                end
            end
            ICACHE_FILL: begin
                // a fill always runs to completion, regardless of redirects or halt
                iREN = 1'b1;
                if (!iwait) begin
                    fill_we = 1'b1;
                    state_d = ICACHE_IDLE;
                end
            end
            default: state_d = ICACHE_IDLE;
        endcase
    end

    assign idle       = (state_q == ICACHE_IDLE);
    assign iaddr      = miss_addr_q;
    assign fill_idx   = miss_addr_q[IDX_W+1:2];
    assign fill_tag   = miss_addr_q[31:IDX_W+2];
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

`default_nettype wire

// File: rtl/icache_direct.sv
//============================================================================
// Module : icache_direct
// Brief  : Direct-mapped read-only instruction cache, one word per frame.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module icache_direct
    import cpu_types_pkg::*;
#(
    parameter int SETS  = ICACHE_SETS,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic            CLK,
    input  logic            nRST,
    icache_direct_if.slave  bus,
    output word_t           hit_count,
    output word_t           miss_count
);

    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [TAG_W-1:0] tag_d  [SETS];
    word_t            data_q [SETS];
    word_t            data_d [SETS];

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             match;
    logic             idle;
    logic             ihit;
    logic             fill_we;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;

    assign req_idx = bus.imemaddr[IDX_W+1:2];
    assign req_tag = bus.imemaddr[31:IDX_W+2];
    assign match   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // hits are suppressed during FILL so a hit and a refill write never coincide
    assign ihit         = bus.imemREN && idle && match;
    assign bus.ihit     = ihit;
    assign bus.imemload = ihit ? data_q[req_idx] : '0;

    icache_ctrl #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_ctrl (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (bus.imemREN),
        .imemaddr   (bus.imemaddr),
        .match      (match),
        .ihit       (ihit),
        .halt       (bus.halt),
        .iwait      (bus.iwait),
        .idle       (idle),
        .iREN       (bus.iREN),
        .iaddr      (bus.iaddr),
        .fill_we    (fill_we),
        .fill_idx   (fill_idx),
        .fill_tag   (fill_tag),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_we) begin
            valid_d[fill_idx] = 1'b1;
            tag_d[fill_idx]   = fill_tag;
            data_d[fill_idx]  = bus.iload;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    // tag/data are qualified by valid, so they need no reset
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

`default_nettype wire
